// File: rtl/lsu_mem_port_if.sv
// Bus bundle for lsu_mem_port: LSU request/response handshakes plus the memory-model access port.
// slave = the lsu_mem_port view; master = the surrounding LSU stage and memory model.
interface lsu_mem_port_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_size;
  logic              req_signed;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic                mem_valid;
  logic                mem_wen;
  logic [ADDR_W-1:0]   mem_raddr;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_signed,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_signed,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store front-end for the memory model: align, lane-shift, extend.
// Optional LSU_MISALIGN_CHECK_EN: misaligned requests skip memory and return resp_err = 1.
module lsu_mem_port #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input logic           clk,
  input logic           rst,
  lsu_mem_port_if.slave bus
);
  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_RESP
  } state_e;

  state_e r_state;
  state_e w_next;

  logic              r_wen;
  logic              r_signed;
  logic [1:0]        r_size;
  logic [2:0]        r_off;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [MASK_W-1:0] r_mem_wmask;
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept;
  logic              w_to_err;
  logic [MASK_W-1:0] w_base_mask;
  logic [DATA_W-1:0] w_rd_shift;

  function automatic logic [DATA_W-1:0] f_extend(input logic [DATA_W-1:0] d,
                                                 input logic [1:0] size,
                                                 input logic sgn);
    logic [DATA_W-1:0] res;
    res = d;
    case (size)
      2'd0:    res = {{(DATA_W-8){sgn & d[7]}}, d[7:0]};
      2'd1:    res = {{(DATA_W-16){sgn & d[15]}}, d[15:0]};
      2'd2:    res = {{(DATA_W-32){sgn & d[31]}}, d[31:0]};
      default: res = d;
    endcase
    return res;
  endfunction

`ifdef LSU_MISALIGN_CHECK_EN
  logic w_misaligned;
  logic r_err;

  always_comb begin
    w_misaligned = 1'b0;
    case (bus.req_size)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = bus.req_addr[0];
      2'd2:    w_misaligned = |bus.req_addr[1:0];
      default: w_misaligned = |bus.req_addr[2:0];
    endcase
  end

  assign w_to_err = w_misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_to_err;
    end
  end

  assign bus.resp_err = r_err;
`else
  assign w_to_err     = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;

  always_comb begin
    w_base_mask = MASK_W'(8'hFF);
    case (bus.req_size)
      2'd0:    w_base_mask = MASK_W'(8'h01);
      2'd1:    w_base_mask = MASK_W'(8'h03);
      2'd2:    w_base_mask = MASK_W'(8'h0F);
      default: w_base_mask = MASK_W'(8'hFF);
    endcase
  end

  // Upper bytes shift in as zero, so misaligned loads see zero-filled lanes before extension.
  assign w_rd_shift = bus.mem_rdata >> {r_off, 3'b000};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid) w_next = w_to_err ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = S_CAPT;
      S_CAPT:  w_next = S_RESP;
      S_RESP:  if (bus.resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen       <= 1'b0;
      r_signed    <= 1'b0;
      r_size      <= '0;
      r_off       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
      r_rdata     <= '0;
    end else begin
      if (w_accept) begin
        r_wen    <= bus.req_wen;
        r_signed <= bus.req_signed;
        r_size   <= bus.req_size;
        r_off    <= bus.req_addr[2:0];
        if (w_to_err) begin
          r_rdata <= '0;
        end else begin
          r_mem_addr  <= {bus.req_addr[ADDR_W-1:3], 3'b000};
          r_mem_wdata <= bus.req_wdata << {bus.req_addr[2:0], 3'b000};
          r_mem_wmask <= w_base_mask << bus.req_addr[2:0];
        end
      end
      if (r_state == S_CAPT) begin
        r_rdata <= r_wen ? '0 : f_extend(w_rd_shift, r_size, r_signed);
      end
    end
  end

  // The strobe is gated by rst directly so a reset in ISSUE never reaches memory.
  assign bus.mem_valid  = (r_state == S_ISSUE) && !rst;
  assign bus.mem_wen    = (r_state == S_ISSUE) && !rst && r_wen;
  assign bus.mem_raddr  = r_mem_addr;
  assign bus.mem_waddr  = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_wmask  = r_mem_wmask;

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_rdata;
endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: vector table with response scoreboard,
// plus hand-written backpressure and reset-during-issue sequences.
module tb_lsu_mem_port;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_port_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  lsu_mem_port #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] mrd;
    logic        mis;
    logic [31:0] e_addr;
    logic [7:0]  e_mask;
    logic [63:0] e_wdata;
    logic [63:0] e_rdata;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb[$];
  vec_t  tbl[12];
  vec_t  cur;
  int    n_cmp = 0;
  int    n_fail = 0;
  int    strobes = 0;
  logic  strobe_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: returns the current vector's read word the cycle after a strobe, junk otherwise.
  initial begin
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_rdata = strobe_seen ? cur.mrd : 64'hDEAD_0BAD_DEAD_0BAD;
    end
  end

  // Monitors: memory strobe contents and scoreboard pop on response handshake.
  always @(negedge clk) begin
    strobe_seen = bus.mem_valid;
    if (bus.mem_valid) begin
      strobes++;
      chk("mem_wen",   {63'd0, bus.mem_wen}, {63'd0, cur.wen});
      chk("mem_raddr", {32'd0, bus.mem_raddr}, {32'd0, cur.e_addr});
      chk("mem_waddr", {32'd0, bus.mem_waddr}, {32'd0, cur.e_addr});
      chk("mem_wmask", {56'd0, bus.mem_wmask}, {56'd0, cur.e_mask});
      chk("mem_wdata", bus.mem_wdata, cur.e_wdata);
    end
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_resp", 64'd1, 64'd0);
      end else begin
        resp_t e;
        e = sb.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_err", {63'd0, bus.resp_err}, {63'd0, e.err});
      end
    end
  end

  task automatic drive_req(input vec_t v);
    cur            = v;
    bus.req_wen    = v.wen;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.req_size   = v.size;
    bus.req_signed = v.sgn;
    bus.req_valid  = 1'b1;
  endtask

  function automatic resp_t exp_resp(input vec_t v);
    resp_t r;
    r.err   = CHK & v.mis;
    r.rdata = r.err ? 64'd0 : v.e_rdata;
    return r;
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic run_vec(input vec_t v);
    int    lat;
    resp_t e;
    e       = exp_resp(v);
    strobes = 0;
    drive_req(v);
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < 20);
    chk("latency", 64'(lat), e.err ? 64'd1 : 64'd3);
    chk("ready_busy", {63'd0, bus.req_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("strobe_count", 64'(strobes), e.err ? 64'd0 : 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int    lat;
    vec_t  v;
    logic [63:0] held;

    //         wen   addr          wdata                   sz    sgn   mrd                     mis   e_addr        e_mask  e_wdata                 e_rdata
    tbl[0]  = '{1'b1, 32'h8000_0004, 64'h0000_0000_DEAD_BEEF, 2'd2, 1'b0, 64'h0,                  1'b0, 32'h8000_0000, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0};
    tbl[1]  = '{1'b0, 32'h8000_0003, 64'h0,                  2'd0, 1'b1, 64'h0000_0000_80FF_0000, 1'b0, 32'h8000_0000, 8'h08, 64'h0,                  64'hFFFF_FFFF_FFFF_FF80};
    tbl[2]  = '{1'b0, 32'h8000_0003, 64'h0,                  2'd0, 1'b0, 64'h0000_0000_80FF_0000, 1'b0, 32'h8000_0000, 8'h08, 64'h0,                  64'h0000_0000_0000_0080};
    tbl[3]  = '{1'b0, 32'h8000_0006, 64'h0,                  2'd1, 1'b1, 64'h8001_0000_0000_0000, 1'b0, 32'h8000_0000, 8'hC0, 64'h0,                  64'hFFFF_FFFF_FFFF_8001};
    tbl[4]  = '{1'b0, 32'h1000_0000, 64'h0,                  2'd2, 1'b1, 64'h0000_0000_8765_4321, 1'b0, 32'h1000_0000, 8'h0F, 64'h0,                  64'hFFFF_FFFF_8765_4321};
    tbl[5]  = '{1'b0, 32'h0000_2008, 64'h0,                  2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 32'h0000_2008, 8'hFF, 64'h0,                  64'h0123_4567_89AB_CDEF};
    tbl[6]  = '{1'b1, 32'h0000_0007, 64'h0000_0000_0000_00AB, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'h0000_0000, 8'h80, 64'hAB00_0000_0000_0000, 64'h0};
    tbl[7]  = '{1'b1, 32'h0000_0040, 64'h1122_3344_5566_7788, 2'd3, 1'b0, 64'h0,                  1'b0, 32'h0000_0040, 8'hFF, 64'h1122_3344_5566_7788, 64'h0};
    tbl[8]  = '{1'b1, 32'h0000_0032, 64'h0000_0000_0000_BEEF, 2'd1, 1'b0, 64'h0,                  1'b0, 32'h0000_0030, 8'h0C, 64'h0000_0000_BEEF_0000, 64'h0};
    tbl[9]  = '{1'b0, 32'h8000_0001, 64'h0,                  2'd1, 1'b0, 64'h0000_0000_00CD_AB12, 1'b1, 32'h8000_0000, 8'h06, 64'h0,                  64'h0000_0000_0000_CDAB};
    tbl[10] = '{1'b1, 32'h0000_0004, 64'h1122_3344_5566_7788, 2'd3, 1'b0, 64'h0,                  1'b1, 32'h0000_0000, 8'hF0, 64'h5566_7788_0000_0000, 64'h0};
    tbl[11] = '{1'b0, 32'h0000_0006, 64'h0,                  2'd2, 1'b1, 64'h8899_AABB_CCDD_EEFF, 1'b1, 32'h0000_0000, 8'hC0, 64'h0,                  64'h0000_0000_0000_8899};

    cur            = tbl[0];
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_size   = '0;
    bus.req_signed = 1'b0;
    bus.resp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_req_ready",  {63'd0, bus.req_ready},  64'd1);
      chk("idle_mem_valid",  {63'd0, bus.mem_valid},  64'd0);
      chk("idle_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
      if (i == 0) begin
        chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
        chk("rst_resp_err",   {63'd0, bus.resp_err},  64'd0);
        chk("rst_mem_wen",    {63'd0, bus.mem_wen},   64'd0);
        chk("rst_mem_raddr",  {32'd0, bus.mem_raddr}, 64'd0);
        chk("rst_mem_waddr",  {32'd0, bus.mem_waddr}, 64'd0);
        chk("rst_mem_wdata",  bus.mem_wdata, 64'd0);
        chk("rst_mem_wmask",  {56'd0, bus.mem_wmask}, 64'd0);
      end
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      run_vec(tbl[i]);
    end

    // Backpressure: response must hold while resp_ready is low; a pending request is ignored.
    v       = tbl[1];
    strobes = 0;
    bus.resp_ready = 1'b0;
    drive_req(v);
    sb.push_back(exp_resp(v));
    @(posedge clk);
    #1;
    bus.req_wen   = 1'b1;
    bus.req_addr  = 32'h0000_0100;
    bus.req_wdata = 64'h5A5A_5A5A_5A5A_5A5A;
    bus.req_size  = 2'd3;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < 20);
    chk("bp_latency", 64'(lat), 64'd3);
    held = bus.resp_rdata;
    chk("bp_first_rdata", held, 64'hFFFF_FFFF_FFFF_FF80);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
      chk("bp_resp_rdata", bus.resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      chk("bp_req_ready",  {63'd0, bus.req_ready},  64'd0);
    end
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {63'd0, bus.resp_valid}, 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("bp_idle_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("bp_idle_req_ready",  {63'd0, bus.req_ready},  64'd1);
    repeat (3) @(negedge clk);
    chk("bp_no_extra_strobe", 64'(strobes), 64'd1);
    @(posedge clk);
    #1;

    // Reset pulsed during ISSUE drops the in-flight store.
    strobes = 0;
    drive_req(tbl[7]);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_issue_mem_valid", {63'd0, bus.mem_valid}, 64'd0);
    chk("rst_issue_mem_wen",   {63'd0, bus.mem_wen},   64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready",  {63'd0, bus.req_ready},  64'd1);
    chk("post_rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("post_rst_resp_rdata", bus.resp_rdata, 64'd0);
    chk("post_rst_resp_err",   {63'd0, bus.resp_err},  64'd0);
    chk("post_rst_mem_valid",  {63'd0, bus.mem_valid}, 64'd0);
    chk("post_rst_mem_waddr",  {32'd0, bus.mem_waddr}, 64'd0);
    chk("post_rst_mem_raddr",  {32'd0, bus.mem_raddr}, 64'd0);
    chk("post_rst_mem_wdata",  bus.mem_wdata, 64'd0);
    chk("post_rst_mem_wmask",  {56'd0, bus.mem_wmask}, 64'd0);
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_resp", {63'd0, bus.resp_valid}, 64'd0);
    end
    chk("post_rst_strobes", 64'(strobes), 64'd0);
    @(posedge clk);
    #1;

    run_vec(tbl[3]);

    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
